// File: rtl/clock_pkg.sv
// Shared constants and types for the clock timekeeping / time-setting controller.
package clock_pkg;

    localparam int KEY_MODE = 0;
    localparam int KEY_SEL  = 1;
    localparam int KEY_INC  = 2;
    localparam int KEY_DEC  = 3;
    localparam int KEY_OK   = 4;

    localparam logic [1:0] FLD_HOUR = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_SEC  = 2'd2;

    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

endpackage

// File: rtl/wrap_step.sv
// Combinational single step (+1 or -1) over 0..MAX with wrap-around at either end.
module wrap_step #(
    parameter int W    = 6,
    parameter int MAX  = 59,
    parameter bit DOWN = 1'b0
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] TOP = W'(MAX);

    always_comb begin
        if (DOWN) result = (value == '0) ? TOP : value - W'(1);
        else      result = (value == TOP) ? '0 : value + W'(1);
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Live time with 1 s prescaler plus a shadow copy edited by key pulses in SET mode.
//   state | meaning
//   RUN   | display live time, only the mode key acts
//   SET   | display shadow time, keys edit / commit / cancel, selected field blinks
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_pulse,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       set_mode,
    output logic [1:0] field,
    output logic       blink,
    output logic       sec_tick
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ - 1);
    localparam logic [BW-1:0] BLK_TC = BW'(BLINK_DIV - 1);
    localparam logic [5:0]    MS_TOP = 6'(MINSEC_MAX);

    state_t          state;
    logic [PW-1:0]   presc;
    logic [BW-1:0]   bcnt;
    logic [4:0]      lv_h, sh_h, nx_h, ed_h;
    logic [5:0]      lv_m, sh_m, nx_m, ed_m;
    logic [5:0]      lv_s, sh_s, nx_s, ed_s;
    logic [4:0]      lv_h_inc, sh_h_inc, sh_h_dec;
    logic [5:0]      lv_m_inc, sh_m_inc, sh_m_dec;
    logic [5:0]      lv_s_inc, sh_s_inc, sh_s_dec;
    logic            tick;
    logic            k_mode, k_ok, k_sel, k_inc, k_dec, any_key;

    wrap_step #(.W(5), .MAX(HOUR_MAX),   .DOWN(1'b0)) u_lv_h (.value(lv_h), .result(lv_h_inc));
    wrap_step #(.W(6), .MAX(MINSEC_MAX), .DOWN(1'b0)) u_lv_m (.value(lv_m), .result(lv_m_inc));
    wrap_step #(.W(6), .MAX(MINSEC_MAX), .DOWN(1'b0)) u_lv_s (.value(lv_s), .result(lv_s_inc));
    wrap_step #(.W(5), .MAX(HOUR_MAX),   .DOWN(1'b0)) u_hi   (.value(sh_h), .result(sh_h_inc));
    wrap_step #(.W(6), .MAX(MINSEC_MAX), .DOWN(1'b0)) u_mi   (.value(sh_m), .result(sh_m_inc));
    wrap_step #(.W(6), .MAX(MINSEC_MAX), .DOWN(1'b0)) u_si   (.value(sh_s), .result(sh_s_inc));
    wrap_step #(.W(5), .MAX(HOUR_MAX),   .DOWN(1'b1)) u_hd   (.value(sh_h), .result(sh_h_dec));
    wrap_step #(.W(6), .MAX(MINSEC_MAX), .DOWN(1'b1)) u_md   (.value(sh_m), .result(sh_m_dec));
    wrap_step #(.W(6), .MAX(MINSEC_MAX), .DOWN(1'b1)) u_sd   (.value(sh_s), .result(sh_s_dec));

    assign tick    = (presc == PRE_TC);
    assign any_key = |key_pulse;

    // Priority mode > ok > select > inc > dec; only the winner acts.
    assign k_mode = key_pulse[KEY_MODE];
    assign k_ok   = key_pulse[KEY_OK] & ~k_mode;
    assign k_sel  = key_pulse[KEY_SEL] & ~key_pulse[KEY_MODE] & ~key_pulse[KEY_OK];
    assign k_inc  = key_pulse[KEY_INC] & ~key_pulse[KEY_MODE] & ~key_pulse[KEY_OK]
                  & ~key_pulse[KEY_SEL];
    assign k_dec  = key_pulse[KEY_DEC] & ~key_pulse[KEY_MODE] & ~key_pulse[KEY_OK]
                  & ~key_pulse[KEY_SEL] & ~key_pulse[KEY_INC];

    always_comb begin
        nx_h = lv_h;
        nx_m = lv_m;
        nx_s = lv_s;
        if (tick) begin
            nx_s = lv_s_inc;
            if (lv_s == MS_TOP) begin
                nx_m = lv_m_inc;
                if (lv_m == MS_TOP) nx_h = lv_h_inc;
            end
        end
    end

    always_comb begin
        ed_h = sh_h;
        ed_m = sh_m;
        ed_s = sh_s;
        if (k_inc) begin
            case (field)
                FLD_HOUR: ed_h = sh_h_inc;
                FLD_MIN:  ed_m = sh_m_inc;
                default:  ed_s = sh_s_inc;
            endcase
        end else if (k_dec) begin
            case (field)
                FLD_HOUR: ed_h = sh_h_dec;
                FLD_MIN:  ed_m = sh_m_dec;
                default:  ed_s = sh_s_dec;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            presc    <= '0;
            bcnt     <= '0;
            lv_h     <= '0;
            lv_m     <= '0;
            lv_s     <= '0;
            sh_h     <= '0;
            sh_m     <= '0;
            sh_s     <= '0;
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
            set_mode <= 1'b0;
            field    <= FLD_HOUR;
            blink    <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            presc    <= tick ? '0 : presc + PW'(1);
            lv_h     <= nx_h;
            lv_m     <= nx_m;
            lv_s     <= nx_s;
            case (state)
                RUN: begin
                    blink  <= 1'b0;
                    bcnt   <= '0;
                    hour   <= nx_h;
                    minute <= nx_m;
                    second <= nx_s;
                    if (k_mode) begin
                        state    <= SET;
                        set_mode <= 1'b1;
                        field    <= FLD_HOUR;
                        sh_h     <= nx_h;
                        sh_m     <= nx_m;
                        sh_s     <= nx_s;
                    end
                end
                SET: begin
                    if (k_mode) begin
                        state    <= RUN;
                        set_mode <= 1'b0;
                        blink    <= 1'b0;
                        bcnt     <= '0;
                        hour     <= nx_h;
                        minute   <= nx_m;
                        second   <= nx_s;
                    end else if (k_ok) begin
                        // Commit overrides any tick landing this cycle and restarts the second.
                        state    <= RUN;
                        set_mode <= 1'b0;
                        blink    <= 1'b0;
                        bcnt     <= '0;
                        presc    <= '0;
                        lv_h     <= sh_h;
                        lv_m     <= sh_m;
                        lv_s     <= sh_s;
                        hour     <= sh_h;
                        minute   <= sh_m;
                        second   <= sh_s;
                    end else begin
                        sh_h   <= ed_h;
                        sh_m   <= ed_m;
                        sh_s   <= ed_s;
                        hour   <= ed_h;
                        minute <= ed_m;
                        second <= ed_s;
                        if (any_key) begin
                            blink <= 1'b0;
                            bcnt  <= '0;
                        end else if (bcnt == BLK_TC) begin
                            blink <= ~blink;
                            bcnt  <= '0;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                        if (k_sel) field <= (field == FLD_SEC) ? FLD_HOUR : field + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: a cycle model queues expected outputs, popped after each edge.
module tb_time_set_ctrl;

    localparam int CF = 10;
    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key_pulse = 5'd0;
    logic [4:0] hour;
    logic [5:0] minute, second;
    logic       set_mode, blink, sec_tick;
    logic [1:0] field;

    always #5 clk = ~clk;

    time_set_ctrl #(.CLK_FREQ(CF), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse),
        .hour(hour), .minute(minute), .second(second),
        .set_mode(set_mode), .field(field), .blink(blink), .sec_tick(sec_tick)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ticks = 0;
    int last_tick = -1;
    int gap_min = 1000, gap_max = 0;
    logic [21:0] exp_q[$];

    int m_pre, m_live, m_fld, m_bcnt;
    int m_sh[3];
    bit m_set, m_blink, m_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_live = 0; m_fld = 0; m_bcnt = 0;
        m_sh[0] = 0; m_sh[1] = 0; m_sh[2] = 0;
        m_set = 0; m_blink = 0; m_tick = 0;
    endtask

    task automatic model_step(input logic [4:0] k);
        bit tick;
        int adv, act, lim;
        tick   = (m_pre == CF - 1);
        m_tick = tick;
        m_pre  = tick ? 0 : m_pre + 1;
        adv    = tick ? (m_live + 1) % 86400 : m_live;
        act    = k[0] ? 0 : k[4] ? 4 : k[1] ? 1 : k[2] ? 2 : k[3] ? 3 : -1;
        if (!m_set) begin
            m_live = adv; m_blink = 0; m_bcnt = 0;
            if (act == 0) begin
                m_set = 1; m_fld = 0;
                m_sh[0] = adv / 3600; m_sh[1] = (adv / 60) % 60; m_sh[2] = adv % 60;
            end
        end else if (act == 0) begin
            m_live = adv; m_set = 0; m_blink = 0; m_bcnt = 0;
        end else if (act == 4) begin
            m_live = m_sh[0] * 3600 + m_sh[1] * 60 + m_sh[2];
            m_pre = 0; m_set = 0; m_blink = 0; m_bcnt = 0;
        end else begin
            m_live = adv;
            if (act < 0) begin
                if (m_bcnt == BD - 1) begin m_bcnt = 0; m_blink = !m_blink; end
                else m_bcnt++;
            end else begin
                m_blink = 0; m_bcnt = 0;
                if (act == 1) m_fld = (m_fld + 1) % 3;
                else begin
                    lim = (m_fld == 0) ? 24 : 60;
                    if (act == 2) m_sh[m_fld] = (m_sh[m_fld] + 1) % lim;
                    else          m_sh[m_fld] = (m_sh[m_fld] + lim - 1) % lim;
                end
            end
        end
    endtask

    function automatic logic [21:0] model_snap();
        int h, m, s;
        if (m_set) begin h = m_sh[0]; m = m_sh[1]; s = m_sh[2]; end
        else begin h = m_live / 3600; m = (m_live / 60) % 60; s = m_live % 60; end
        return {5'(h), 6'(m), 6'(s), m_set, 2'(m_fld), m_blink, m_tick};
    endfunction

    function automatic logic [21:0] dut_snap();
        return {hour, minute, second, set_mode, field, blink, sec_tick};
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [4:0] k);
        logic [21:0] e;
        key_pulse = k;
        model_step(k);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        key_pulse = 5'd0;
        cyc++;
        e = exp_q.pop_front();
        check($sformatf("cyc%0d", cyc), 32'(dut_snap()), 32'(e));
        if (sec_tick) begin
            ticks++;
            if (last_tick >= 0) begin
                if (cyc - last_tick < gap_min) gap_min = cyc - last_tick;
                if (cyc - last_tick > gap_max) gap_max = cyc - last_tick;
            end
            last_tick = cyc;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(5'd0);
    endtask

    initial begin
        int t0, i;
        model_reset();
        #2;
        check("reset_state", 32'(dut_snap()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(600);
        check("tick_count", ticks, 60);
        check("tick_gap_min", gap_min, 10);
        check("tick_gap_max", gap_max, 10);
        check("time_1min", {hour, minute, second}, {5'd0, 6'd1, 6'd0});
        check("run_flags", {set_mode, blink}, 2'b00);

        step(5'h01);
        step(5'h08);
        step(5'h02);
        i = 0;
        while (m_sh[1] != 59 && i < 70) begin step(5'h08); i++; end
        step(5'h02);
        i = 0;
        while (m_sh[2] != 59 && i < 70) begin step(5'h08); i++; end
        check("preload_shadow", {hour, minute, second}, {5'd23, 6'd59, 6'd59});
        step(5'h10);
        run(9);
        check("before_wrap", {hour, minute, second}, {5'd23, 6'd59, 6'd59});
        step(5'h00);
        check("midnight_wrap", {hour, minute, second, sec_tick}, {5'd0, 6'd0, 6'd0, 1'b1});

        step(5'h01);
        step(5'h08);
        step(5'h02);
        step(5'h04); step(5'h04); step(5'h04);
        step(5'h10);
        t0 = cyc;
        check("commit_value", {hour, minute, set_mode}, {5'd23, 6'd3, 1'b0});
        check("commit_second", 32'(second), 32'(m_sh[2]));
        for (int j = 0; j < 20 && !sec_tick; j++) step(5'h00);
        check("commit_to_tick", cyc - t0, 10);

        step(5'h01);
        for (int j = 0; j < 6; j++) step(5'h04);
        check("edit_hour5", {hour, set_mode}, {5'd5, 1'b1});
        run(30);
        step(5'h01);
        check("cancel_hour", {hour, minute, set_mode}, {5'd23, 6'd3, 1'b0});

        step(5'h05);
        check("mode_inc_enter", {set_mode, 32'(second)}, {1'b1, 32'(m_live % 60)});
        step(5'h14);
        check("ok_inc_commit", {set_mode, hour, minute}, {1'b0, 5'd23, 6'd3});

        step(5'h01);
        run(3);
        check("blink_low", blink, 1'b0);
        step(5'h00);
        check("blink_toggle", blink, 1'b1);
        run(2);
        step(5'h02);
        check("blink_key_clr", blink, 1'b0);
        run(3);
        check("blink_low2", blink, 1'b0);
        step(5'h00);
        check("blink_toggle2", blink, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        check("reset_in_set", {set_mode, hour, minute, second, blink}, 19'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
